inv_roundkey_gen: RTL and testbench

Decryption-side AES-128 key schedule: accepts the round-10 key (last four expansion words) and regenerates the round keys backward, round 10 down to round 0, one per valid/ready handshake. It sits beside the forward round-key generator and feeds the inverse cipher datapath, which consumes keys in reverse order. Only one 128-bit key register is held, with no 11-entry key store. It uses a shared 4-byte S-box instance in the same style as the forward path.

---
 rtl/inv_roundkey_gen.sv | 174 +++++++++++++++++
 tb/tb_inv_roundkey_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_roundkey_gen.sv
// Backward AES-128 key schedule: loads the round-10 key and replays round keys 10..0 over valid/ready.
// Define INV_KEY_SBOX_REG_EN to register the S-box result and split each backward step over two cycles.
module inv_roundkey_gen (
    input  logic        clk,
    input  logic        areset,
    input  logic        i_start,
    input  logic [31:0] last_word_1,
    input  logic [31:0] last_word_2,
    input  logic [31:0] last_word_3,
    input  logic [31:0] last_word_4,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [3:0]  o_round,
    output logic [31:0] o_word_1,
    output logic [31:0] o_word_2,
    output logic [31:0] o_word_3,
    output logic [31:0] o_word_4,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_SUB  = 2'd2
    } state_t;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse (x^254, 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;     // {k0, k1, k2, k3}, k0 = w[4r] in [127:96]
    logic [3:0]   round_q, round_d;
    logic         done_q, done_d;
`ifdef INV_KEY_SBOX_REG_EN
    logic [31:0]  sub_q, sub_d;
`endif

    logic [31:0]  n1, n2, n3;
    logic [31:0]  sub_rot;
    logic         accept;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
`ifdef INV_KEY_SBOX_REG_EN
            sub_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            done_q  <= done_d;
`ifdef INV_KEY_SBOX_REG_EN
            sub_q   <= sub_d;
`endif
        end
    end

    // Single shared 4-byte S-box; Rcon is indexed by the round being left, before the decrement.
    always_comb begin
        n3      = key_q[31:0]  ^ key_q[63:32];
        n2      = key_q[63:32] ^ key_q[95:64];
        n1      = key_q[95:64] ^ key_q[127:96];
        sub_rot = sub_word({n3[23:0], n3[31:24]}) ^ {rcon(round_q), 24'h000000};
        accept  = (state_q == ST_EMIT) && i_ready;
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
`ifdef INV_KEY_SBOX_REG_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    key_d   = {last_word_1, last_word_2, last_word_3, last_word_4};
                    round_d = 4'd10;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (accept) begin
                    if (round_q == 4'd0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        round_d = round_q - 4'd1;
`ifdef INV_KEY_SBOX_REG_EN
                        key_d   = {key_q[127:96], n1, n2, n3};
                        sub_d   = sub_rot;
                        state_d = ST_SUB;
`else
                        key_d   = {key_q[127:96] ^ sub_rot, n1, n2, n3};
`endif
                    end
                end
            end
`ifdef INV_KEY_SBOX_REG_EN
            ST_SUB: begin
                key_d   = {key_q[127:96] ^ sub_q, key_q[95:0]};
                state_d = ST_EMIT;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_valid  = (state_q == ST_EMIT);
        o_busy   = (state_q != ST_IDLE);
        o_round  = round_q;
        o_done   = done_q;
        o_word_1 = key_q[127:96];
        o_word_2 = key_q[95:64];
        o_word_3 = key_q[63:32];
        o_word_4 = key_q[31:0];
    end

endmodule

// File: tb/tb_inv_roundkey_gen.sv
// Bench for inv_roundkey_gen: expected keys come from a forward AES-128 key expansion of the
// chosen cipher key; a cycle-level protocol model checks every output on every falling edge.
module tb_inv_roundkey_gen;

`ifdef INV_KEY_SBOX_REG_EN
    localparam bit SUBMODE = 1'b1;
`else
    localparam bit SUBMODE = 1'b0;
`endif

    logic        clk;
    logic        areset;
    logic        i_start;
    logic [31:0] last_word_1, last_word_2, last_word_3, last_word_4;
    logic        i_ready;
    logic        o_valid;
    logic [3:0]  o_round;
    logic [31:0] o_word_1, o_word_2, o_word_3, o_word_4;
    logic        o_busy;
    logic        o_done;

    inv_roundkey_gen dut (
        .clk         (clk),
        .areset      (areset),
        .i_start     (i_start),
        .last_word_1 (last_word_1),
        .last_word_2 (last_word_2),
        .last_word_3 (last_word_3),
        .last_word_4 (last_word_4),
        .i_ready     (i_ready),
        .o_valid     (o_valid),
        .o_round     (o_round),
        .o_word_1    (o_word_1),
        .o_word_2    (o_word_2),
        .o_word_3    (o_word_3),
        .o_word_4    (o_word_4),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    logic [7:0] sbox_tab [0:255];

    function automatic logic [31:0] tb_sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    // Keys the stimulus is currently driving (round 0..10), and the ones the model has loaded.
    logic [127:0] drv_keys [0:10];
    logic [127:0] m_keys   [0:10];

    task automatic set_drive_key(input logic [127:0] cipher_key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = cipher_key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = tb_sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) drv_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        last_word_1 = w[40];
        last_word_2 = w[41];
        last_word_3 = w[42];
        last_word_4 = w[43];
    endtask

    // Protocol model state, describing the cycle after the most recent falling edge.
    bit           m_active = 1'b0;
    bit           m_sub    = 1'b0;
    bit           m_done   = 1'b0;
    logic [3:0]   m_round  = 4'd0;
    logic [127:0] m_hold   = '0;

    bit           prev_stall = 1'b0;
    logic [127:0] prev_words;
    logic [3:0]   prev_round;
    logic [127:0] cap [0:10];
    int           done_count = 0;

    always @(negedge clk) begin
        logic [127:0] words;
        bit           exp_valid;
        bit           nxt_done;
        words = {o_word_1, o_word_2, o_word_3, o_word_4};
        if (!areset) begin
            m_active = 1'b0;
            m_sub    = 1'b0;
            m_done   = 1'b0;
            m_round  = 4'd0;
            m_hold   = '0;
        end
        exp_valid = m_active && !m_sub;
        check("o_valid", {127'b0, o_valid}, {127'b0, exp_valid});
        check("o_busy",  {127'b0, o_busy},  {127'b0, m_active});
        check("o_done",  {127'b0, o_done},  {127'b0, m_done});
        check("o_round", {124'b0, o_round}, {124'b0, m_round});
        if (!m_sub) check("o_words", words, exp_valid ? m_keys[m_round] : m_hold);
        if (prev_stall) begin
            check("stall_words", words, prev_words);
            check("stall_round", {124'b0, o_round}, {124'b0, prev_round});
        end
        prev_stall = areset && o_valid && !i_ready;
        prev_words = words;
        prev_round = o_round;
        if (o_valid && i_ready) cap[o_round] = words;
        if (o_done) done_count++;
        if (areset) begin
            nxt_done = 1'b0;
            if (!m_active) begin
                if (i_start) begin
                    m_active = 1'b1;
                    m_round  = 4'd10;
                    m_keys   = drv_keys;
                end
            end else if (m_sub) begin
                m_sub = 1'b0;
            end else if (i_ready) begin
                if (m_round == 4'd0) begin
                    m_active = 1'b0;
                    nxt_done = 1'b1;
                    m_hold   = m_keys[0];
                end else begin
                    m_round = m_round - 4'd1;
                    m_sub   = SUBMODE;
                end
            end
            m_done = nxt_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] cipher_key);
        set_drive_key(cipher_key);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic run_to_end(input bit rand_ready);
        int n;
        n = 0;
        while (m_active && n < 200) begin
            i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        check("run_timeout", {127'b0, m_active}, 128'd0);
    endtask

    task automatic run_until_round(input logic [3:0] r);
        int n;
        n = 0;
        while (!(m_active && !m_sub && m_round == r) && n < 200) begin
            i_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("round_wait_timeout", {124'b0, m_round}, {124'b0, r});
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int done_base;
        sbox_tab = '{
            8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
            8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
            8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
            8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
            8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
            8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
            8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
            8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
            8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
            8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
            8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
            8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
            8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
            8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
            8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
            8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
        for (int r = 0; r <= 10; r++) begin
            drv_keys[r] = '0;
            m_keys[r]   = '0;
            cap[r]      = '0;
        end
        areset      = 1'b0;
        i_start     = 1'b0;
        i_ready     = 1'b0;
        last_word_1 = '0;
        last_word_2 = '0;
        last_word_3 = '0;
        last_word_4 = '0;
        repeat (3) tick();
        areset = 1'b1;
        tick();

        // Pin the reference expansion against FIPS-197 literals.
        set_drive_key(FIPS_KEY);
        check("model_r10", drv_keys[10], FIPS_R10);
        check("model_r9",  drv_keys[9],  FIPS_R9);
        check("model_r1",  drv_keys[1],  FIPS_R1);

        // FIPS key, consumer always ready.
        done_base = done_count;
        load_key(FIPS_KEY);
        run_to_end(1'b0);
        check("fips_r9", cap[9], FIPS_R9);
        check("fips_r1", cap[1], FIPS_R1);
        check("fips_r0", cap[0], FIPS_KEY);

        // Back-to-back load in the o_done cycle, random ready, stray start at round 5.
        for (int r = 0; r <= 10; r++) cap[r] = '0;
        load_key(FIPS_KEY);
        check("done_pulses_first_run", done_count - done_base, 1);
        run_until_round(4'd5);
        set_drive_key({$urandom, $urandom, $urandom, $urandom});
        i_start = 1'b1;
        i_ready = 1'($urandom_range(0, 1));
        tick();
        i_start = 1'b0;
        run_to_end(1'b1);
        check("rand_ready_r9", cap[9], FIPS_R9);
        check("rand_ready_r1", cap[1], FIPS_R1);
        check("rand_ready_r0", cap[0], FIPS_KEY);

        // Reset in the middle of a sequence, then a fresh load.
        load_key({$urandom, $urandom, $urandom, $urandom});
        run_until_round(4'd6);
        done_base = done_count;
        areset = 1'b0;
        tick();
        tick();
        areset = 1'b1;
        tick();
        check("no_done_after_reset", done_count - done_base, 0);
        load_key({$urandom, $urandom, $urandom, $urandom});
        run_to_end(1'b1);

        // Further random keys with random backpressure.
        for (int k = 0; k < 4; k++) begin
            load_key({$urandom, $urandom, $urandom, $urandom});
            run_to_end(1'b1);
        end
        i_ready = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
